mem_port_arbiter: RTL

- Sequences and shares the single-ported asynchronous main memory between two requesters: port A (CPU) and port B (loader/DMA).
- Grants one access at a time using round-robin arbitration.
- Inserts a programmable number of wait cycles so read data is sampled only after the memory's combinational access delay has settled.
- Sits between the multi-cycle CPU/loader and async_mem, and drives async_mem's read, write, address and write_data pins.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 17 +
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; the last-served pointer lives in the parent.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic valid,
    output logic pick_b
);

    always_comb begin
        valid  = req_a | req_b;
        pick_b = req_b & (~req_a | (last_b == PORT_A));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported asynchronous memory between ports A and B, holding
// mem_read for WAIT_CYCLES cycles so read data settles before capture.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              busy,
    output logic              grant_b
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic              last_b;
    logic              arb_valid;
    logic              arb_pick_b;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req_a  (a_req),
        .req_b  (b_req),
        .last_b (last_b),
        .valid  (arb_valid),
        .pick_b (arb_pick_b)
    );

    always_comb begin
        sel_we    = arb_pick_b ? b_we    : a_we;
        sel_addr  = arb_pick_b ? b_addr  : a_addr;
        sel_wdata = arb_pick_b ? b_wdata : a_wdata;
    end

    // Memory strobes are flops set on entry to ACCESS, so no req reaches a memory pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            we_q           <= 1'b0;
            last_b         <= PORT_B;
            grant_b        <= PORT_A;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            a_rdata        <= '0;
            b_rdata        <= '0;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            busy           <= 1'b0;
        end else begin
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant_b        <= arb_pick_b;
                        last_b         <= arb_pick_b;
                        mem_addr       <= sel_addr;
                        mem_write_data <= sel_wdata;
                        we_q           <= sel_we;
                        mem_write      <= sel_we;
                        mem_read       <= ~sel_we;
                        cnt            <= sel_we ? '0 : CNT_LOAD;
                        busy           <= 1'b1;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (we_q || cnt == '0) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= RESP;
                        if (grant_b == PORT_B) begin
                            b_ack <= 1'b1;
                            if (!we_q) b_rdata <= mem_read_data;
                        end else begin
                            a_ack <= 1'b1;
                            if (!we_q) a_rdata <= mem_read_data;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
